// File: rtl/zet_ng_wb_sram_slave.sv
// Wishbone B3 classic target backed by a 16-bit on-chip scratchpad RAM.
// Supports byte-selected single accesses, programmable wait states,
// incrementing bursts, and an error response for out-of-range addresses.
module zet_ng_wb_sram_slave #(
  parameter int AW         = 19,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [1:0]    wb_sel_i,
  input  logic [15:0]   wb_dat_i,
  input  logic [2:0]    wb_cti_i,
  output logic [15:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          busy_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT);
  localparam logic [2:0] CTI_INCR  = 3'b010;

  typedef enum logic [1:0] {IDLE, WAITST, RESP, BURST} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  we_q;
  logic [1:0]            sel_q;
  logic                  range_q;
  logic [3:0]            waitcnt_q;
  logic [15:0]           dat_hold_q;
  logic [15:0]           mem [2**DEPTH_LOG2];

  logic                  req;
  logic                  in_range;
  logic                  beat;
  logic                  wr_en;

  // A held strobe is never accepted again while its response is still visible.
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign in_range = (wb_adr_i >> DEPTH_LOG2) == '0;
  assign beat     = wb_cyc_i & wb_stb_i & ((state_q == RESP) | (state_q == BURST));
  assign wr_en    = wb_ack_o & we_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; dropping cyc anywhere outside IDLE aborts the cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = (WAIT_INIT == 4'd0) ? RESP : WAITST;
      end
      WAITST: begin
        if (!wb_cyc_i)              state_d = IDLE;
        else if (waitcnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        if (!wb_cyc_i) state_d = IDLE;
        else if (wb_stb_i) begin
          if (wb_ack_o && (wb_cti_i == CTI_INCR)) state_d = BURST;
          else                                    state_d = IDLE;
        end
      end
      BURST: begin
        if (!wb_cyc_i)                               state_d = IDLE;
        else if (wb_stb_i && (wb_cti_i != CTI_INCR)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; responses are gated by live cyc/stb so an abort suppresses them
  always_comb begin
    wb_ack_o = beat & range_q;
    wb_err_o = beat & ~range_q & (state_q == RESP);
    busy_o   = (state_q != IDLE);
    wb_dat_o = (wb_ack_o & ~we_q) ? mem[addr_q] : dat_hold_q;
  end

  // Request capture, wait counter, burst address counter and read-data hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      range_q    <= 1'b0;
      waitcnt_q  <= '0;
      dat_hold_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q    <= wb_adr_i[DEPTH_LOG2-1:0];
        we_q      <= wb_we_i;
        sel_q     <= wb_sel_i;
        range_q   <= in_range;
        waitcnt_q <= WAIT_INIT;
      end
      if (state_q == WAITST) begin
        if (!wb_cyc_i) waitcnt_q <= '0;
        else           waitcnt_q <= waitcnt_q - 4'd1;
      end
      // Counter advances on every acked beat and wraps at the RAM size
      if (wb_ack_o) begin
        addr_q <= addr_q + DEPTH_LOG2'(1);
        if (!we_q) dat_hold_q <= mem[addr_q];
      end
    end
  end

  // RAM write port; byte lanes committed on the ack edge only
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (sel_q[0]) mem[addr_q][7:0]  <= wb_dat_i[7:0];
      if (sel_q[1]) mem[addr_q][15:8] <= wb_dat_i[15:8];
    end
  end

endmodule

// File: tb/tb_zet_ng_wb_sram_slave.sv
// Directed bench for zet_ng_wb_sram_slave with WAIT = 2, DEPTH_LOG2 = 10.
module tb_zet_ng_wb_sram_slave;

  localparam int WAIT_ST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [18:0] adr;
  logic [1:0]  sel;
  logic [15:0] dat_w;
  logic [2:0]  cti;
  logic [15:0] dat_r;
  logic        ack, err, busy;

  int n_checks = 0;
  int n_pass   = 0;

  zet_ng_wb_sram_slave #(.AW(19), .DEPTH_LOG2(10), .WAIT(WAIT_ST)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (dat_w),
    .wb_cti_i (cti),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  // Single classic access: response expected WAIT_ST+1 cycles after the request edge
  task automatic wb_single(input logic w, input logic [18:0] a, input logic [1:0] s,
                           input logic [15:0] d, input logic exp_err,
                           input logic [15:0] exp_rd, input string tag);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d; cti = 3'b000;
    @(posedge clk);
    for (int c = 1; c <= WAIT_ST; c++) begin
      @(negedge clk);
      check({tag, "_wait"}, {29'd0, busy, ack, err}, 32'b100);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_resp"}, {30'd0, ack, err}, exp_err ? 32'b01 : 32'b10);
    if (!w && !exp_err) check({tag, "_data"}, {16'd0, dat_r}, {16'd0, exp_rd});
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check({tag, "_idle"}, {29'd0, busy, ack, err}, 32'b000);
    if (!w && !exp_err) check({tag, "_hold"}, {16'd0, dat_r}, {16'd0, exp_rd});
  endtask

  initial begin
    rst = 1'b0; bus_idle(); adr = '0; sel = '0; dat_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {13'd0, busy, ack, err, dat_r}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Write then read back
    wb_single(1'b1, 19'd5, 2'b11, 16'hBEEF, 1'b0, 16'h0000, "wr5");
    wb_single(1'b0, 19'd5, 2'b11, 16'h0000, 1'b0, 16'hBEEF, "rd5");

    // Byte selects
    wb_single(1'b1, 19'd5, 2'b01, 16'h1234, 1'b0, 16'h0000, "wr5_lo");
    wb_single(1'b0, 19'd5, 2'b00, 16'h0000, 1'b0, 16'hBE34, "rd5_lo");
    wb_single(1'b1, 19'd6, 2'b11, 16'h0F0F, 1'b0, 16'h0000, "wr6");
    wb_single(1'b1, 19'd6, 2'b10, 16'hABCD, 1'b0, 16'h0000, "wr6_hi");
    wb_single(1'b0, 19'd6, 2'b11, 16'h0000, 1'b0, 16'hAB0F, "rd6_hi");

    // Out of range: error only, no aliasing onto low addresses
    wb_single(1'b0, 19'h00400, 2'b11, 16'h0000, 1'b1, 16'h0000, "oor_rd");
    wb_single(1'b1, 19'h00405, 2'b11, 16'h0000, 1'b1, 16'h0000, "oor_wr");
    wb_single(1'b1, 19'h40005, 2'b11, 16'hDEAD, 1'b1, 16'h0000, "oor_wr_hi");
    wb_single(1'b0, 19'd5, 2'b11, 16'h0000, 1'b0, 16'hBE34, "rd5_after_oor");

    // Incrementing burst write across the wrap point
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 19'd1022; sel = 2'b11;
    dat_w = 16'd1; cti = 3'b010;
    @(posedge clk);
    for (int c = 1; c <= WAIT_ST; c++) begin
      @(negedge clk);
      check("burst_wait", {29'd0, busy, ack, err}, 32'b100);
      @(posedge clk);
    end
    @(negedge clk);
    check("burst_beat1", {30'd0, ack, err}, 32'b10);
    for (int b = 2; b <= 4; b++) begin
      @(posedge clk); #1;
      dat_w = 16'(b);
      cti   = (b == 4) ? 3'b111 : 3'b010;
      @(negedge clk);
      check("burst_beat", {30'd0, ack, err}, 32'b10);
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("burst_idle", {29'd0, busy, ack, err}, 32'b000);
    wb_single(1'b0, 19'd1022, 2'b11, 16'h0000, 1'b0, 16'd1, "rd1022");
    wb_single(1'b0, 19'd1023, 2'b11, 16'h0000, 1'b0, 16'd2, "rd1023");
    wb_single(1'b0, 19'd0,    2'b11, 16'h0000, 1'b0, 16'd3, "rd0");
    wb_single(1'b0, 19'd1,    2'b11, 16'h0000, 1'b0, 16'd4, "rd1");

    // Burst with a stalled beat (stb low holds state, no ack)
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 19'd10; sel = 2'b11;
    dat_w = 16'h00A0; cti = 3'b010;
    @(posedge clk);
    repeat (WAIT_ST) @(posedge clk);
    @(negedge clk);
    check("stall_beat1", {30'd0, ack, err}, 32'b10);
    @(posedge clk); #1;
    stb = 1'b0; dat_w = 16'hFFFF;
    @(negedge clk);
    check("stall_gap", {29'd0, busy, ack, err}, 32'b100);
    @(posedge clk); #1;
    stb = 1'b1; dat_w = 16'h00A1; cti = 3'b111;
    @(negedge clk);
    check("stall_beat2", {30'd0, ack, err}, 32'b10);
    @(posedge clk); #1;
    bus_idle();
    wb_single(1'b0, 19'd11, 2'b11, 16'h0000, 1'b0, 16'h00A1, "rd11");

    // Abort during WAITST
    wb_single(1'b1, 19'd7, 2'b11, 16'h5555, 1'b0, 16'h0000, "wr7");
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 19'd7; sel = 2'b11;
    dat_w = 16'hAAAA; cti = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check("abort_ws_busy", {29'd0, busy, ack, err}, 32'b100);
    #1 bus_idle();
    @(negedge clk);
    check("abort_ws_idle", {29'd0, busy, ack, err}, 32'b000);
    wb_single(1'b0, 19'd7, 2'b11, 16'h0000, 1'b0, 16'h5555, "rd7_ws");

    // Abort in the response cycle: no ack, no write
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 19'd7; sel = 2'b11;
    dat_w = 16'hAAAA; cti = 3'b000;
    @(posedge clk);
    repeat (WAIT_ST) @(posedge clk);
    #1 bus_idle();
    @(negedge clk);
    check("abort_resp", {29'd0, busy, ack, err}, 32'b100);
    @(negedge clk);
    check("abort_resp_idle", {29'd0, busy, ack, err}, 32'b000);
    wb_single(1'b0, 19'd7, 2'b11, 16'h0000, 1'b0, 16'h5555, "rd7_resp");

    // Asynchronous reset while waiting
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 19'd5; sel = 2'b11; cti = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_busy", {29'd0, busy, ack, err}, 32'b100);
    #1 rst = 1'b0;
    #1;
    check("rst_async", {13'd0, busy, ack, err, dat_r}, 32'd0);
    bus_idle();
    @(posedge clk); #1 rst = 1'b1;
    wb_single(1'b0, 19'd5, 2'b11, 16'h0000, 1'b0, 16'hBE34, "rd5_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zet_ng_wb_sram_slave.md
Name: zet_ng_wb_sram_slave

Overview:
- Wishbone B3 classic target (responder) for the zet_ng SoC core bus. It answers the core's initiator cycles with a 16-bit on-chip scratchpad RAM.
- Supports single reads/writes with byte selects, a programmable number of wait states, incrementing bursts (CTI 010), and an error response for out-of-range addresses.
- Sits on the core data bus behind the address decoder; one instance per RAM region.

Parameters:
- AW, 19, word-address width of wb_adr_i.
- DEPTH_LOG2, 10, log2 of RAM depth in 16-bit words (default 1024 words).
- WAIT, 1, wait states inserted before the first ack/err of a cycle (0..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  AW  word address.
- wb_sel_i  in  2  byte selects; [0] = bits 7:0, [1] = bits 15:8.
- wb_dat_i  in  16  write data.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_dat_o  out  16  read data, valid while wb_ack_o = 1.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- busy_o  out  1  high while the FSM is outside IDLE.

Behaviour:
- Reset (rst = 0, asynchronous): wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 16'h0000, busy_o = 0, FSM = IDLE, wait counter = 0. RAM contents are not reset.
- Request: wb_cyc_i & wb_stb_i sampled high in IDLE.
- In range: wb_adr_i[AW-1:DEPTH_LOG2] == 0. Otherwise out of range.

FSM states:
- IDLE: on a request, latch the address into an internal counter addr_q, latch we/sel/range, load waitcnt = WAIT.
  - WAIT = 0: go to RESP.
  - WAIT > 0: go to WAITST.
- WAITST: decrement waitcnt each cycle; go to RESP when waitcnt reaches 1.
- RESP: drive a one-cycle wb_ack_o (in range) or wb_err_o (out of range).
  - Write with ack: commit wb_dat_i bytes selected by wb_sel_i to RAM[addr_q] on the ack edge.
  - Read: wb_dat_o = RAM[addr_q] while ack is high; bytes with sel = 0 are still returned.
  - Next state: if wb_cti_i == 010, the response was ack, and stb is still high, go to BURST; else go to IDLE.
- BURST: addr_q increments by 1 per beat, wrapping modulo 2^DEPTH_LOG2. wb_ack_o is asserted every cycle stb is high, with no wait states after the first beat; wb_dat_i is written per beat.
  - Beat with wb_cti_i == 111 is the final ack; return to IDLE.
  - stb low in BURST: hold state with ack low.
- Latency: first ack/err rises WAIT+1 cycles after the request edge.
  - Worked example, WAIT = 1: request sampled at edge 0, ack high in cycle 2.
- Double-ack guard: in IDLE, a request is not accepted in the cycle where wb_ack_o or wb_err_o is high, so a held stb is not answered twice.
- Aborts:
  - wb_cyc_i falls in WAITST, RESP or BURST: return to IDLE next edge.
  - The abort-cycle ack/err is suppressed, and no write occurs for an unacked beat.
- Error: wb_err_o is a single cycle. Never burst; no RAM access. wb_ack_o and wb_err_o are never high together.
- wb_dat_o holds its last read value when ack is low.
- Reset mid-cycle: outputs clear immediately. Only writes already acked persist.
- busy_o = (state != IDLE).

Test Plan:
- Write then read, WAIT = 2: write 16'hBEEF to addr 5, sel = 11 → ack in cycle 3 after request. Read addr 5 → ack in cycle 3, dat_o = BEEF.
- Byte select: write 16'h1234 with sel = 01 over BEEF → read returns BE34.
- Out of range (DEPTH_LOG2 = 10): read addr 0x400 → wb_err_o pulses once after WAIT+1 cycles, ack stays 0, RAM unchanged.
- Burst, WAIT = 1: 4-beat incrementing write of 1, 2, 3, 4 starting at addr 1022, CTI 010, 010, 010, 111 → acks on 4 consecutive cycles after the initial wait. Read back: addr 1022 = 1, 1023 = 2, 0 = 3, 1 = 4 (wrap).
- Abort: drop cyc during WAITST of a write to addr 7 → no ack, RAM[7] unchanged, busy_o low next cycle.
- Reset mid-wait: rst = 0 during WAITST → ack/err/busy low immediately. After release a new read succeeds with normal latency.
